// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: control-bit indices,
// default widths and the beat payload layout.
package pipe_pkg;

  localparam int unsigned CTRL_SYSCALL  = 0;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 2;
  localparam int unsigned CTRL_MEMWRITE = 3;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_DATA_DEF = 2;
  localparam int unsigned CTRL_W_DEF   = 4;
  localparam int unsigned REG_W_DEF    = 5;

  // Beat payload at the default widths (ctrl in the MSBs, rd in the LSBs).
  typedef struct packed {
    logic [CTRL_W_DEF-1:0]                ctrl;
    logic [NUM_DATA_DEF*DATA_W_DEF-1:0]   data;
    logic [31:0]                          instr;
    logic [REG_W_DEF-1:0]                 wreg;
    logic [REG_W_DEF-1:0]                 rd;
  } payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid bit plus payload register with load, clear and synchronous reset.
module pipe_slot #(
  parameter int unsigned W        = 8,
  parameter bit          ZERO_CLR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] pay_i,
  output logic         valid_o,
  output logic [W-1:0] pay_o
);

  logic         valid_q;
  logic [W-1:0] pay_q;

  // Clear wins over load; a cleared slot reads as a zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      if (ZERO_CLR) pay_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pay_q   <= pay_i;
    end
  end

  assign valid_o = valid_q;
  assign pay_o   = pay_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// flush-to-bubble and hazard taps. MAIN drives the outputs, SKID is overflow.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned NUM_DATA     = NUM_DATA_DEF,
  parameter int unsigned CTRL_W       = CTRL_W_DEF,
  parameter int unsigned REGWRITE_BIT = CTRL_REGWRITE,
  parameter int unsigned MEMTOREG_BIT = CTRL_MEMTOREG,
  parameter int unsigned REG_W        = REG_W_DEF,
  parameter bit          ZERO_BUBBLE  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [31:0]                in_instr,
  input  logic [REG_W-1:0]           in_wreg,
  input  logic [REG_W-1:0]           in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [31:0]                out_instr,
  output logic [REG_W-1:0]           out_wreg,
  output logic [REG_W-1:0]           out_rd,
  output logic                       haz_regwrite,
  output logic                       haz_memtoreg,
  output logic [REG_W-1:0]           haz_wreg,
  output logic [1:0]                 occ
);

  localparam int unsigned DW    = NUM_DATA * DATA_W;
  localparam int unsigned PAY_W = CTRL_W + DW + 32 + 2 * REG_W;

  logic             main_v, skid_v;
  logic [PAY_W-1:0] main_pay, skid_pay, in_pay, main_d;
  logic             accept, rel;
  logic             main_load, main_clr, skid_load, skid_clr;

  assign in_pay = {in_ctrl, in_data, in_instr, in_wreg, in_rd};
  assign accept = in_valid & ~skid_v;
  assign rel    = main_v & out_ready;

  // Slot control from (occupancy, accept, release); flush empties both slots.
  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_d    = in_pay;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (skid_v) begin
      if (rel) begin
        main_load = 1'b1;
        main_d    = skid_pay;
        skid_clr  = 1'b1;
      end
    end else if (main_v) begin
      if (accept && rel) begin
        main_load = 1'b1;
      end else if (rel) begin
        main_clr = 1'b1;
      end else if (accept) begin
        skid_load = 1'b1;
      end
    end else if (accept) begin
      main_load = 1'b1;
    end
  end

  pipe_slot #(.W(PAY_W), .ZERO_CLR(ZERO_BUBBLE)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clr),
    .pay_i   (main_d),
    .valid_o (main_v),
    .pay_o   (main_pay)
  );

  pipe_slot #(.W(PAY_W), .ZERO_CLR(ZERO_BUBBLE)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clr),
    .pay_i   (in_pay),
    .valid_o (skid_v),
    .pay_o   (skid_pay)
  );

  assign {out_ctrl, out_data, out_instr, out_wreg, out_rd} = main_pay;
  assign out_valid = main_v;
  assign in_ready  = ~skid_v;
  assign occ       = 2'(main_v) + 2'(skid_v);

  assign haz_regwrite = out_ctrl[REGWRITE_BIT] & out_valid;
  assign haz_memtoreg = out_ctrl[MEMTOREG_BIT] & out_valid;
  assign haz_wreg     = out_valid ? out_wreg : '0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: the driver pushes accepted beats into
// an ordered queue, the monitor checks the outputs against the queue head.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned DW = NUM_DATA_DEF * DATA_W_DEF;

  logic                  clk;
  logic                  rst, flush, in_valid, out_ready;
  logic                  in_ready, out_valid;
  logic [CTRL_W_DEF-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0]         in_data, out_data;
  logic [31:0]           in_instr, out_instr;
  logic [REG_W_DEF-1:0]  in_wreg, in_rd, out_wreg, out_rd, haz_wreg;
  logic                  haz_regwrite, haz_memtoreg;
  logic [1:0]            occ;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_instr(in_instr),
    .in_wreg(in_wreg), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_instr(out_instr),
    .out_wreg(out_wreg), .out_rd(out_rd),
    .haz_regwrite(haz_regwrite), .haz_memtoreg(haz_memtoreg),
    .haz_wreg(haz_wreg), .occ(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: beats accepted and not yet released/squashed, oldest first.
  payload_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs must present the oldest outstanding beat, or a zero bubble.
  payload_t mon_f;
  logic     mon_v;
  always @(negedge clk) begin
    mon_v = (exp_q.size() > 0);
    mon_f = mon_v ? exp_q[0] : '0;
    check("out_valid",    64'(out_valid),    64'(mon_v));
    check("in_ready",     64'(in_ready),     64'(exp_q.size() < 2));
    check("occ",          64'(occ),          64'(exp_q.size()));
    check("out_instr",    64'(out_instr),    64'(mon_f.instr));
    check("out_ctrl",     64'(out_ctrl),     64'(mon_f.ctrl));
    check("out_data",     64'(out_data),     64'(mon_f.data));
    check("out_wreg",     64'(out_wreg),     64'(mon_f.wreg));
    check("out_rd",       64'(out_rd),       64'(mon_f.rd));
    check("haz_regwrite", 64'(haz_regwrite), 64'(mon_v & mon_f.ctrl[CTRL_REGWRITE]));
    check("haz_memtoreg", 64'(haz_memtoreg), 64'(mon_v & mon_f.ctrl[CTRL_MEMTOREG]));
    check("haz_wreg",     64'(haz_wreg),     64'(mon_f.wreg));
    if (rst || flush) exp_q.delete();
    else if (mon_v && out_ready) void'(exp_q.pop_front());
  end

  function automatic payload_t rand_pay();
    payload_t p;
    p.ctrl  = CTRL_W_DEF'($urandom);
    p.data  = {$urandom, $urandom};
    p.instr = $urandom;
    p.wreg  = REG_W_DEF'($urandom);
    p.rd    = REG_W_DEF'($urandom);
    return p;
  endfunction

  function automatic payload_t instr_pay(input logic [31:0] instr);
    payload_t p;
    p       = rand_pay();
    p.instr = instr;
    return p;
  endfunction

  // One clock of stimulus; a beat is accepted when fewer than two are held.
  task automatic cycle(input logic iv, input payload_t p, input logic ordy,
                       input logic fl, input logic rs);
    int held;
    @(posedge clk); #1;
    in_valid  = iv;
    {in_ctrl, in_data, in_instr, in_wreg, in_rd} = p;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    held      = exp_q.size();
    @(negedge clk); #1;
    if (iv && held < 2 && !fl && !rs) exp_q.push_back(p);
  endtask

  payload_t hp;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_ctrl = '0; in_data = '0; in_instr = 32'h8C410004; in_wreg = '0; in_rd = '0;

    // Reset held two cycles with a valid beat offered.
    cycle(1'b1, instr_pay(32'h8C410004), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, instr_pay(32'h8C410004), 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("reset_occ",      64'(occ),       64'd0);
    check("reset_in_ready", 64'(in_ready),  64'd1);
    check("reset_instr",    64'(out_instr), 64'd0);

    // Streaming with downstream always ready.
    for (int i = 1; i <= 3; i++) cycle(1'b1, instr_pay(32'(i)), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Skid: backpressure for three cycles while upstream keeps offering.
    cycle(1'b1, instr_pay(32'd10), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, instr_pay(32'd11), 1'b1, 1'b0, 1'b0);
    for (int i = 12; i <= 14; i++) cycle(1'b1, instr_pay(32'(i)), 1'b0, 1'b0, 1'b0);
    check("skid_occ",      64'(occ),      64'd2);
    check("skid_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with two held beats and an incoming beat.
    cycle(1'b1, instr_pay(32'd20), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, instr_pay(32'd21), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, instr_pay(32'd22), 1'b1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("flush_occ",   64'(occ),          64'd0);
    check("flush_valid", 64'(out_valid),    64'd0);
    check("flush_hazrw", 64'(haz_regwrite), 64'd0);
    check("flush_hazwr", 64'(haz_wreg),     64'd0);
    check("flush_instr", 64'(out_instr),    64'd0);

    // Hazard taps on a held load-type beat, then after release.
    hp = rand_pay();
    hp.ctrl = 4'b0110;
    hp.wreg = 5'd9;
    cycle(1'b1, hp, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("haz_rw_held", 64'(haz_regwrite), 64'd1);
    check("haz_mr_held", 64'(haz_memtoreg), 64'd1);
    check("haz_wr_held", 64'(haz_wreg),     64'd9);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("haz_rw_empty", 64'(haz_regwrite), 64'd0);
    check("haz_mr_empty", 64'(haz_memtoreg), 64'd0);
    check("haz_wr_empty", 64'(haz_wreg),     64'd0);

    // Reset and flush together mid-stream.
    cycle(1'b1, instr_pay(32'd30), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, instr_pay(32'd31), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, instr_pay(32'd32), 1'b1, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("rstfl_occ",      64'(occ),       64'd0);
    check("rstfl_in_ready", 64'(in_ready),  64'd1);
    check("rstfl_valid",    64'(out_valid), 64'd0);

    // Random valid/ready traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'(($urandom % 4) != 0), rand_pay(), 1'(($urandom % 3) != 0),
            1'(($urandom % 64) == 0), 1'(($urandom % 256) == 0));
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drain_occ", 64'(occ), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
